// File: rtl/exec_pkg.sv
// exec_pkg
// Shared encodings for the execute stage: ALU operation codes, forward
// select codes, branch funct3 values, result-select encodings and the
// packed control bundle carried through the ID/EX register.
package exec_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [2:0] ALU_SLL = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;

   // 2'b11 is unused by the hazard unit and falls back to the register file
   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic       jump;
      logic       branch;
      logic       alu_src;
      logic       jalr;
      logic [1:0] result_src;
      logic [2:0] alu_ctrl;
      logic [2:0] funct3;
   } idex_ctrl_t;

endpackage

// File: rtl/exec_alu.sv
// exec_alu
// Combinational ALU for the execute stage.
// Ports:
//   SrcA, SrcB  - operands
//   ALUControl  - operation (exec_pkg ALU_* codes)
//   ALUResult   - result, add/sub wrap modulo 2^WIDTH
//   Zero        - ALUResult == 0
module exec_alu
   import exec_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic [2:0]       ALUControl,
   output logic [WIDTH-1:0] ALUResult,
   output logic             Zero
);

   always_comb begin
      ALUResult = '0;
      case (ALUControl)
         ALU_ADD: ALUResult = SrcA + SrcB;
         ALU_SUB: ALUResult = SrcA - SrcB;
         ALU_AND: ALUResult = SrcA & SrcB;
         ALU_OR:  ALUResult = SrcA | SrcB;
         ALU_XOR: ALUResult = SrcA ^ SrcB;
         ALU_SLT: ALUResult = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
         ALU_SLL: ALUResult = SrcA << SrcB[4:0];
         ALU_SRL: ALUResult = SrcA >> SrcB[4:0];
         default: ALUResult = '0;
      endcase
   end

   assign Zero = (ALUResult == '0);

endmodule

// File: rtl/execute_stage.sv
// execute_stage
// Execute stage of the 5-stage reduced RISC-V pipeline. Holds the flushable
// ID/EX register, selects forwarded operands, runs the ALU, resolves
// branches/jumps and produces the fetch redirect target.
// Ports:
//   clk, rst            - clock, async active-high reset
//   flush               - synchronous bubble insert into ID/EX
//   *D                  - decode-stage control, data and register addresses
//   ForwardAE/BE        - operand forward selects from the hazard unit
//   ALUResultM, ResultW - forwarded values from MEM and WB
//   *E                  - registered control/addresses and execute results
//   PCSrcE              - redirect fetch to PCTargetE
// Build option:
//   EXECUTE_FORWARDING_EN - when defined the forward muxes are active; when
//   undefined operands come straight from the ID/EX register and the forward
//   inputs are ignored (the hazard unit must stall instead).
module execute_stage
   import exec_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             RegWriteD,
   input  logic             MemWriteD,
   input  logic             JumpD,
   input  logic             BranchD,
   input  logic             ALUSrcD,
   input  logic             JALRctrlD,
   input  logic [1:0]       ResultSrcD,
   input  logic [2:0]       ALUControlD,
   input  logic [2:0]       Funct3D,
   input  logic [WIDTH-1:0] RD1D,
   input  logic [WIDTH-1:0] RD2D,
   input  logic [WIDTH-1:0] ImmExtD,
   input  logic [WIDTH-1:0] PCD,
   input  logic [WIDTH-1:0] PCPlus4D,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       RdD,
   input  logic [1:0]       ForwardAE,
   input  logic [1:0]       ForwardBE,
   input  logic [WIDTH-1:0] ALUResultM,
   input  logic [WIDTH-1:0] ResultW,
   output logic             RegWriteE,
   output logic             MemWriteE,
   output logic [1:0]       ResultSrcE,
   output logic [WIDTH-1:0] ALUResultE,
   output logic [WIDTH-1:0] WriteDataE,
   output logic [WIDTH-1:0] PCPlus4E,
   output logic [WIDTH-1:0] PCTargetE,
   output logic [4:0]       RdE,
   output logic [4:0]       Rs1E,
   output logic [4:0]       Rs2E,
   output logic             PCSrcE
);

   idex_ctrl_t       ctrl_d, ctrl_q;
   logic [WIDTH-1:0] rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q;
   logic [WIDTH-1:0] pc_d, pc_q, pc4_d, pc4_q;
   logic [4:0]       rs1_d, rs1_q, rs2_d, rs2_q, rdx_d, rdx_q;

   // Flush loads an all-zero bubble: no write, no branch, no jump.
   always_comb begin
      ctrl_d = '0;
      rd1_d  = '0;
      rd2_d  = '0;
      imm_d  = '0;
      pc_d   = '0;
      pc4_d  = '0;
      rs1_d  = '0;
      rs2_d  = '0;
      rdx_d  = '0;
      if (!flush) begin
         ctrl_d.reg_write  = RegWriteD;
         ctrl_d.mem_write  = MemWriteD;
         ctrl_d.jump       = JumpD;
         ctrl_d.branch     = BranchD;
         ctrl_d.alu_src    = ALUSrcD;
         ctrl_d.jalr       = JALRctrlD;
         ctrl_d.result_src = ResultSrcD;
         ctrl_d.alu_ctrl   = ALUControlD;
         ctrl_d.funct3     = Funct3D;
         rd1_d             = RD1D;
         rd2_d             = RD2D;
         imm_d             = ImmExtD;
         pc_d              = PCD;
         pc4_d             = PCPlus4D;
         rs1_d             = Rs1D;
         rs2_d             = Rs2D;
         rdx_d             = RdD;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q <= '0;
         rd1_q  <= '0;
         rd2_q  <= '0;
         imm_q  <= '0;
         pc_q   <= '0;
         pc4_q  <= '0;
         rs1_q  <= '0;
         rs2_q  <= '0;
         rdx_q  <= '0;
      end else begin
         ctrl_q <= ctrl_d;
         rd1_q  <= rd1_d;
         rd2_q  <= rd2_d;
         imm_q  <= imm_d;
         pc_q   <= pc_d;
         pc4_q  <= pc4_d;
         rs1_q  <= rs1_d;
         rs2_q  <= rs2_d;
         rdx_q  <= rdx_d;
      end
   end

   logic [WIDTH-1:0] src_a, src_b;

`ifdef EXECUTE_FORWARDING_EN
   always_comb begin
      src_a = rd1_q;
      case (ForwardAE)
         FWD_W:   src_a = ResultW;
         FWD_M:   src_a = ALUResultM;
         default: src_a = rd1_q;
      endcase
   end

   always_comb begin
      WriteDataE = rd2_q;
      case (ForwardBE)
         FWD_W:   WriteDataE = ResultW;
         FWD_M:   WriteDataE = ALUResultM;
         default: WriteDataE = rd2_q;
      endcase
   end
`else
   assign src_a      = rd1_q;
   assign WriteDataE = rd2_q;

   logic unused_fwd;
   assign unused_fwd = ^{ForwardAE, ForwardBE, ALUResultM, ResultW};
`endif

   assign src_b = ctrl_q.alu_src ? imm_q : WriteDataE;

   logic zero;

   exec_alu #(.WIDTH(WIDTH)) u_alu (
      .SrcA       (src_a),
      .SrcB       (src_b),
      .ALUControl (ctrl_q.alu_ctrl),
      .ALUResult  (ALUResultE),
      .Zero       (zero)
   );

   logic taken;
   assign taken  = ctrl_q.branch &
                   (((ctrl_q.funct3 == F3_BEQ) & zero) |
                    ((ctrl_q.funct3 == F3_BNE) & ~zero));
   assign PCSrcE = taken | ctrl_q.jump;

   // JALR target uses the forwarded base and clears bit 0.
   logic [WIDTH-1:0] jalr_sum;
   assign jalr_sum  = src_a + imm_q;
   assign PCTargetE = ctrl_q.jalr ? {jalr_sum[WIDTH-1:1], 1'b0} : (pc_q + imm_q);

   assign RegWriteE  = ctrl_q.reg_write;
   assign MemWriteE  = ctrl_q.mem_write;
   assign ResultSrcE = ctrl_q.result_src;
   assign PCPlus4E   = pc4_q;
   assign RdE        = rdx_q;
   assign Rs1E       = rs1_q;
   assign Rs2E       = rs2_q;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, JALRctrlD;
   logic [1:0]    ResultSrcD;
   logic [2:0]    ALUControlD, Funct3D;
   logic [W-1:0]  RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
   logic [4:0]    Rs1D, Rs2D, RdD;
   logic [1:0]    ForwardAE, ForwardBE;
   logic [W-1:0]  ALUResultM, ResultW;
   logic          RegWriteE, MemWriteE, PCSrcE;
   logic [1:0]    ResultSrcE;
   logic [W-1:0]  ALUResultE, WriteDataE, PCPlus4E, PCTargetE;
   logic [4:0]    RdE, Rs1E, Rs2E;

   execute_stage #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
      .ALUSrcD(ALUSrcD), .JALRctrlD(JALRctrlD), .ResultSrcD(ResultSrcD),
      .ALUControlD(ALUControlD), .Funct3D(Funct3D),
      .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ALUResultM(ALUResultM), .ResultW(ResultW),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
      .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
      .PCTargetE(PCTargetE), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E), .PCSrcE(PCSrcE)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] alu, wd, tgt, pc4;
      logic        pcsrc, rw, mw;
      logic [1:0]  rsrc;
      logic [4:0]  rd, rs1, rs2;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t blank(input string tag);
      exp_t e;
      e.tag = tag; e.alu = '0; e.wd = '0; e.tgt = '0; e.pc4 = '0;
      e.pcsrc = 1'b0; e.rw = 1'b0; e.mw = 1'b0; e.rsrc = '0;
      e.rd = '0; e.rs1 = '0; e.rs2 = '0;
      return e;
   endfunction

   function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd6: return a << b[4:0];
         default: return a >> b[4:0];
      endcase
   endfunction

   task automatic nop();
      flush = 0; RegWriteD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0;
      ALUSrcD = 0; JALRctrlD = 0; ResultSrcD = 0; ALUControlD = 0; Funct3D = 0;
      RD1D = 0; RD2D = 0; ImmExtD = 0; PCD = 0; PCPlus4D = 0;
      Rs1D = 0; Rs2D = 0; RdD = 0;
      ForwardAE = 0; ForwardBE = 0; ALUResultM = 0; ResultW = 0;
   endtask

   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk({e.tag, ".alu"},   ALUResultE, e.alu);
         chk({e.tag, ".wd"},    WriteDataE, e.wd);
         chk({e.tag, ".tgt"},   PCTargetE, e.tgt);
         chk({e.tag, ".pc4"},   PCPlus4E, e.pc4);
         chk({e.tag, ".pcsrc"}, 32'(PCSrcE), 32'(e.pcsrc));
         chk({e.tag, ".rw"},    32'(RegWriteE), 32'(e.rw));
         chk({e.tag, ".mw"},    32'(MemWriteE), 32'(e.mw));
         chk({e.tag, ".rsrc"},  32'(ResultSrcE), 32'(e.rsrc));
         chk({e.tag, ".rd"},    32'(RdE), 32'(e.rd));
         chk({e.tag, ".rs1"},   32'(Rs1E), 32'(e.rs1));
         chk({e.tag, ".rs2"},   32'(Rs2E), 32'(e.rs2));
      end
   endtask

   task automatic step(input exp_t e);
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_out();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".alu"},   ALUResultE, 32'd0);
      chk({tag, ".wd"},    WriteDataE, 32'd0);
      chk({tag, ".tgt"},   PCTargetE, 32'd0);
      chk({tag, ".pc4"},   PCPlus4E, 32'd0);
      chk({tag, ".pcsrc"}, 32'(PCSrcE), 32'd0);
      chk({tag, ".rw"},    32'(RegWriteE), 32'd0);
      chk({tag, ".mw"},    32'(MemWriteE), 32'd0);
      chk({tag, ".rsrc"},  32'(ResultSrcE), 32'd0);
      chk({tag, ".rd"},    32'(RdE), 32'd0);
      chk({tag, ".rs1"},   32'(Rs1E), 32'd0);
      chk({tag, ".rs2"},   32'(Rs2E), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t        e;
      logic [31:0] pa [4];
      logic [31:0] pb [4];

      pa[0] = 32'h8000_0003; pb[0] = 32'h0000_0021;
      pa[1] = 32'h1234_5678; pb[1] = 32'hFFFF_FFF4;
      pa[2] = 32'h0000_0000; pb[2] = 32'h0000_0001;
      pa[3] = 32'hFFFF_FFFF; pb[3] = 32'h0000_0002;

      rst = 1'b1;
      nop();
      RD1D = 32'hDEAD_BEEF; PCPlus4D = 32'h44; RegWriteD = 1; RdD = 5'd9;
      #12;
      chk_zero("reset_hold");

      // add 5 + 7
      @(negedge clk);
      rst = 1'b0;
      nop();
      RD1D = 5; RD2D = 7; RegWriteD = 1; RdD = 5'd3; Rs1D = 5'd1; Rs2D = 5'd2; PCPlus4D = 4;
      e = blank("add"); e.alu = 12; e.wd = 7; e.pc4 = 4; e.rw = 1; e.rd = 3; e.rs1 = 1; e.rs2 = 2;
      step(e);

      // forward A from MEM with immediate operand
      @(negedge clk);
      nop();
      RD1D = 1; ImmExtD = 4; ALUSrcD = 1; ForwardAE = 2'b10; ALUResultM = 32'h100;
      e = blank("fwd_a_m"); e.tgt = 4;
`ifdef EXECUTE_FORWARDING_EN
      e.alu = 32'h104;
`else
      e.alu = 32'h5;
`endif
      step(e);

      // forward A from WB
      @(negedge clk);
      nop();
      RD1D = 1; ImmExtD = 4; ALUSrcD = 1; ForwardAE = 2'b01; ResultW = 32'h20; ALUResultM = 32'h100;
      e = blank("fwd_a_w"); e.tgt = 4;
`ifdef EXECUTE_FORWARDING_EN
      e.alu = 32'h24;
`else
      e.alu = 32'h5;
`endif
      step(e);

      // select 11 falls back to register file
      @(negedge clk);
      nop();
      RD1D = 1; ImmExtD = 4; ALUSrcD = 1; ForwardAE = 2'b11; ResultW = 32'h20; ALUResultM = 32'h100;
      e = blank("fwd_a_11"); e.alu = 32'h5; e.tgt = 4;
      step(e);

      // forward B from MEM into both ALU and store data
      @(negedge clk);
      nop();
      RD1D = 1; RD2D = 3; ForwardBE = 2'b10; ALUResultM = 32'h100; ResultW = 32'h20; MemWriteD = 1;
      e = blank("fwd_b_m"); e.mw = 1;
`ifdef EXECUTE_FORWARDING_EN
      e.alu = 32'h101; e.wd = 32'h100;
`else
      e.alu = 32'h4;   e.wd = 32'h3;
`endif
      step(e);

      // beq taken, backward target
      @(negedge clk);
      nop();
      BranchD = 1; Funct3D = 3'b000; ALUControlD = 3'b001; RD1D = 9; RD2D = 9;
      PCD = 32'h40; ImmExtD = 32'hFFFF_FFF8;
      e = blank("beq_taken"); e.alu = 0; e.wd = 9; e.tgt = 32'h38; e.pcsrc = 1;
      step(e);

      // bne with equal operands: not taken
      @(negedge clk);
      nop();
      BranchD = 1; Funct3D = 3'b001; ALUControlD = 3'b001; RD1D = 9; RD2D = 9;
      PCD = 32'h40; ImmExtD = 32'hFFFF_FFF8;
      e = blank("bne_eq"); e.alu = 0; e.wd = 9; e.tgt = 32'h38; e.pcsrc = 0;
      step(e);

      // bne with unequal operands: taken
      @(negedge clk);
      nop();
      BranchD = 1; Funct3D = 3'b001; ALUControlD = 3'b001; RD1D = 9; RD2D = 4;
      PCD = 32'h80; ImmExtD = 32'h10;
      e = blank("bne_ne"); e.alu = 5; e.wd = 4; e.tgt = 32'h90; e.pcsrc = 1;
      step(e);

      // other funct3 never taken, even with zero result
      @(negedge clk);
      nop();
      BranchD = 1; Funct3D = 3'b100; ALUControlD = 3'b001; RD1D = 9; RD2D = 9;
      PCD = 32'h80; ImmExtD = 32'h10;
      e = blank("f3_other"); e.alu = 0; e.wd = 9; e.tgt = 32'h90; e.pcsrc = 0;
      step(e);

      // jalr: target clears bit 0
      @(negedge clk);
      nop();
      JumpD = 1; JALRctrlD = 1; ALUSrcD = 1; RD1D = 32'h1003; ImmExtD = 2; PCPlus4D = 32'h14;
      PCD = 32'h10; RegWriteD = 1; RdD = 5'd1; ResultSrcD = 2'b10; Rs1D = 5'd7;
      e = blank("jalr"); e.alu = 32'h1005; e.tgt = 32'h1004; e.pcsrc = 1; e.pc4 = 32'h14;
      e.rw = 1; e.rd = 1; e.rsrc = 2'b10; e.rs1 = 7;
      step(e);

      // jalr base taken from forwarded MEM value
      @(negedge clk);
      nop();
      JumpD = 1; JALRctrlD = 1; ALUSrcD = 1; RD1D = 0; ImmExtD = 0; PCD = 32'h200;
      ForwardAE = 2'b10; ALUResultM = 32'h2001;
      e = blank("jalr_fwd"); e.pcsrc = 1;
`ifdef EXECUTE_FORWARDING_EN
      e.alu = 32'h2001; e.tgt = 32'h2000;
`else
      e.alu = 32'h0;    e.tgt = 32'h0;
`endif
      step(e);

      // slt signed corners
      @(negedge clk);
      nop();
      ALUControlD = 3'b101; RD1D = 32'hFFFF_FFFF; RD2D = 1;
      e = blank("slt_neg"); e.alu = 1; e.wd = 1;
      step(e);
      @(negedge clk);
      nop();
      ALUControlD = 3'b101; RD1D = 1; RD2D = 32'hFFFF_FFFF;
      e = blank("slt_pos"); e.alu = 0; e.wd = 32'hFFFF_FFFF;
      step(e);

      // sweep every ALU op over a few operand pairs
      for (int op = 0; op < 8; op++) begin
         for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            nop();
            ALUControlD = 3'(op); RD1D = pa[p]; RD2D = pb[p]; PCD = 32'h10;
            ResultSrcD = 2'(p); RdD = 5'(op + 8 * p); Rs1D = 5'(p + 1); Rs2D = 5'(op + 2);
            e = blank($sformatf("op%0d_p%0d", op, p));
            e.alu = ref_alu(3'(op), pa[p], pb[p]); e.wd = pb[p]; e.tgt = 32'h10;
            e.rsrc = 2'(p); e.rd = 5'(op + 8 * p); e.rs1 = 5'(p + 1); e.rs2 = 5'(op + 2);
            step(e);
         end
      end

      // flush while a taken branch sits in EX
      @(negedge clk);
      nop();
      BranchD = 1; ALUControlD = 3'b001; RD1D = 3; RD2D = 3; PCD = 32'h100; ImmExtD = 32'h8;
      RegWriteD = 1; MemWriteD = 1; RdD = 5'd4;
      e = blank("br_before_flush"); e.wd = 3; e.tgt = 32'h108; e.pcsrc = 1; e.rw = 1; e.mw = 1; e.rd = 4;
      step(e);
      @(negedge clk);
      flush = 1;
      #1;
      chk("flush_pre_edge.pcsrc", 32'(PCSrcE), 32'd1);
      e = blank("flush_bubble");
      step(e);

      // async reset between edges
      @(negedge clk);
      nop();
      JumpD = 1; PCD = 32'h100; ImmExtD = 32'h20; PCPlus4D = 32'h104; RegWriteD = 1; RdD = 5'd5;
      e = blank("jal"); e.alu = 0; e.tgt = 32'h120; e.pc4 = 32'h104; e.pcsrc = 1; e.rw = 1; e.rd = 5;
      step(e);
      #2;
      rst = 1'b1;
      #1;
      chk_zero("async_rst");
      @(negedge clk);
      rst = 1'b0;
      nop();
      RD1D = 5; RD2D = 7; RegWriteD = 1; RdD = 5'd3; PCPlus4D = 32'h8;
      #1;
      chk("post_rst_pre_edge.pc4", PCPlus4E, 32'd0);
      e = blank("post_rst_add"); e.alu = 12; e.wd = 7; e.pc4 = 32'h8; e.rw = 1; e.rd = 3;
      step(e);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
